// File: rtl/pattern_match_window_counter.sv
// pattern_match_window_counter
//
// Counts the cycles in which the pattern detector's match pulse z is high, over
// consecutive windows of window_len clock cycles. Each completed window's total
// is reported on count, and count_valid is high for one cycle when a new count
// appears. Windows run back to back while enable is held. alarm and overflow are
// sticky flags for the control logic.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   z             match pulse, counted only while a window is running
//   enable        level; starts windowing and keeps it running
//   clear         synchronous clear of counters, flags and FSM
//   window_len    window length in cycles (0 is treated as 1)
//   threshold     alarm threshold (0 disables the alarm)
//   count         total of the last completed window
//   count_valid   one-cycle strobe marking a new count
//   running_count live accumulator value (pre-add value for this cycle)
//   alarm         sticky, a completed window reached threshold
//   overflow      sticky, z arrived while the accumulator was saturated

module pattern_match_window_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic [CNT_W-1:0] running_count,
  output logic             alarm,
  output logic             overflow
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] AccMax = '1;
  localparam logic [CNT_W-1:0] AccOne = CNT_W'(1);
  localparam logic [WIN_W-1:0] WinOne = WIN_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_valid_q, count_valid_d;
  logic             alarm_q, alarm_d;
  logic             overflow_q, overflow_d;

  logic [WIN_W-1:0] len_eff;
  logic             acc_sat;
  logic [CNT_W-1:0] acc_inc;
  logic [CNT_W-1:0] acc_final;
  logic             last_cycle;

  assign len_eff   = (window_len == '0) ? WinOne : window_len;
  assign acc_sat   = (acc_q == AccMax);
  assign acc_inc   = acc_sat ? acc_q : acc_q + AccOne;
  assign acc_final = z ? acc_inc : acc_q;
  // Timer is always loaded with at least 1, so <= 1 only guards against 0.
  assign last_cycle = (timer_q <= WinOne);

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    timer_d       = timer_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    alarm_d       = alarm_q;
    overflow_d    = overflow_q;

    if (clear) begin
      state_d    = StIdle;
      acc_d      = '0;
      timer_d    = '0;
      count_d    = '0;
      alarm_d    = 1'b0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          acc_d = '0;
          if (enable) state_d = StLoad;
        end
        StLoad: begin
          timer_d = len_eff;
          acc_d   = '0;
          state_d = StRun;
        end
        StRun: begin
          if (last_cycle) begin
            // Window closes: report acc + z, then restart or stop.
            count_d       = acc_final;
            count_valid_d = 1'b1;
            if ((threshold != '0) && (acc_final >= threshold)) alarm_d = 1'b1;
            if (z && acc_sat) overflow_d = 1'b1;
            acc_d = '0;
            if (enable) begin
              timer_d = len_eff;
            end else begin
              timer_d = '0;
              state_d = StIdle;
            end
          end else if (!enable) begin
            // Abort: partial window is discarded, z this cycle is ignored.
            acc_d   = '0;
            timer_d = '0;
            state_d = StIdle;
          end else begin
            acc_d   = acc_final;
            timer_d = timer_q - WinOne;
            if (z && acc_sat) overflow_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          acc_d   = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      timer_q       <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      alarm_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      alarm_q       <= alarm_d;
      overflow_q    <= overflow_d;
    end
  end

  assign count         = count_q;
  assign count_valid   = count_valid_q;
  assign running_count = acc_q;
  assign alarm         = alarm_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_pattern_match_window_counter.sv
// Bench for pattern_match_window_counter: a window-level reference model checked
// on every falling edge, plus directed scenarios with literal expectations.

module tb_pattern_match_window_counter;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WIN_W = 16;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             z = 1'b0;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic [WIN_W-1:0] window_len = '0;
  logic [CNT_W-1:0] threshold = '0;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic [CNT_W-1:0] running_count;
  logic             alarm;
  logic             overflow;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  pattern_match_window_counter #(
    .CNT_W(CNT_W),
    .WIN_W(WIN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .z            (z),
    .enable       (enable),
    .clear        (clear),
    .window_len   (window_len),
    .threshold    (threshold),
    .count        (count),
    .count_valid  (count_valid),
    .running_count(running_count),
    .alarm        (alarm),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Reference model: phase 0 idle, 1 load, 2 run; unbounded match sum,
  // cycles left in the window, and the reported state.
  int m_phase, m_left, m_sum, m_count;
  bit m_cv, m_alarm, m_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_left <= 0; m_sum <= 0; m_count <= 0;
      m_cv <= 1'b0; m_alarm <= 1'b0; m_ovf <= 1'b0;
    end else begin
      m_cv <= 1'b0;
      if (clear) begin
        m_phase <= 0; m_left <= 0; m_sum <= 0; m_count <= 0;
        m_alarm <= 1'b0; m_ovf <= 1'b0;
      end else if (m_phase == 0) begin
        m_sum <= 0;
        if (enable) m_phase <= 1;
      end else if (m_phase == 1) begin
        m_left  <= (window_len == 0) ? 1 : int'(window_len);
        m_sum   <= 0;
        m_phase <= 2;
      end else if (m_left == 1) begin
        m_count <= sat(m_sum + int'(z));
        m_cv    <= 1'b1;
        if (threshold != 0 && sat(m_sum + int'(z)) >= int'(threshold)) m_alarm <= 1'b1;
        if (z && m_sum >= MAXC) m_ovf <= 1'b1;
        m_sum <= 0;
        if (enable) m_left <= (window_len == 0) ? 1 : int'(window_len);
        else m_phase <= 0;
      end else if (!enable) begin
        m_phase <= 0;
        m_sum   <= 0;
      end else begin
        if (z && m_sum >= MAXC) m_ovf <= 1'b1;
        m_sum  <= m_sum + int'(z);
        m_left <= m_left - 1;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model.count", int'(count), m_count);
      chk("model.count_valid", int'(count_valid), int'(m_cv));
      chk("model.running_count", int'(running_count), sat(m_sum));
      chk("model.alarm", int'(alarm), int'(m_alarm));
      chk("model.overflow", int'(overflow), int'(m_ovf));
    end
  end

  // Inputs apply from 2 time units after an edge until 2 after the next edge.
  task automatic tick(input logic zi, input logic ei, input logic ci);
    z = zi; enable = ei; clear = ci;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".count"}, int'(count), 0);
    chk({name, ".count_valid"}, int'(count_valid), 0);
    chk({name, ".running_count"}, int'(running_count), 0);
    chk({name, ".alarm"}, int'(alarm), 0);
    chk({name, ".overflow"}, int'(overflow), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    started = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    chk_all_zero("reset");

    // Basic window: N=4, z=1,0,1,1.
    window_len = 4; threshold = 0;
    tick(0, 1, 0);                   // IDLE -> LOAD
    tick(1, 1, 0);                   // LOAD (z ignored) -> RUN
    chk("basic.rc0", int'(running_count), 0);
    tick(1, 1, 0); chk("basic.rc1", int'(running_count), 1);
    tick(0, 1, 0); chk("basic.rc2", int'(running_count), 1);
    tick(1, 1, 0); chk("basic.rc3", int'(running_count), 2);
    tick(1, 1, 0);
    chk("basic.cv", int'(count_valid), 1);
    chk("basic.count", int'(count), 3);
    tick(0, 0, 0);                   // abort second window
    chk("basic.cv_once", int'(count_valid), 0);
    chk("basic.count_hold", int'(count), 3);

    // Back-to-back windows: N=3, z=1,1,1 then 0,1,0.
    window_len = 3;
    tick(0, 1, 0); tick(0, 1, 0);
    tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
    chk("b2b.cv1", int'(count_valid), 1);
    chk("b2b.count1", int'(count), 3);
    tick(0, 1, 0); chk("b2b.gap1", int'(count_valid), 0);
    tick(1, 1, 0); chk("b2b.gap2", int'(count_valid), 0);
    tick(0, 1, 0);
    chk("b2b.cv2", int'(count_valid), 1);
    chk("b2b.count2", int'(count), 1);
    tick(0, 0, 0);

    // Saturation: N=300, z every cycle, threshold 200, stop at the boundary.
    window_len = 300; threshold = 200;
    tick(0, 1, 0); tick(0, 1, 0);
    for (int i = 0; i < 300; i++) tick(1, (i != 299), 0);
    chk("sat.cv", int'(count_valid), 1);
    chk("sat.count", int'(count), 255);
    chk("sat.overflow", int'(overflow), 1);
    chk("sat.alarm", int'(alarm), 1);
    tick(0, 0, 0);
    chk("sat.cv_off", int'(count_valid), 0);
    chk("sat.overflow_sticky", int'(overflow), 1);
    chk("sat.alarm_sticky", int'(alarm), 1);

    // Mid-window abort: N=10, drop enable after 5 counted cycles.
    window_len = 10; threshold = 0;
    tick(0, 1, 0); tick(0, 1, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 0);
    chk("abort.rc5", int'(running_count), 5);
    tick(1, 0, 0);
    chk("abort.cv", int'(count_valid), 0);
    chk("abort.count", int'(count), 255);
    chk("abort.rc", int'(running_count), 0);
    tick(0, 0, 0);
    chk("abort.idle_cv", int'(count_valid), 0);

    // Clear coinciding with a boundary, alarm and overflow already set.
    window_len = 2;
    tick(0, 1, 0); tick(0, 1, 0);
    tick(1, 1, 0);
    tick(1, 1, 1);
    chk_all_zero("clear");
    tick(1, 1, 0);                   // IDLE -> LOAD proves clear went to IDLE
    tick(1, 1, 0);
    chk("clear.rc_after_load", int'(running_count), 0);
    tick(0, 0, 0);

    // window_len=0 behaves as N=1: a report every cycle.
    window_len = 0; threshold = 1;
    tick(0, 1, 0); tick(0, 1, 0);
    tick(1, 1, 0);
    chk("n1.cv_a", int'(count_valid), 1);
    chk("n1.count_a", int'(count), 1);
    chk("n1.alarm", int'(alarm), 1);
    tick(0, 1, 0);
    chk("n1.cv_b", int'(count_valid), 1);
    chk("n1.count_b", int'(count), 0);
    tick(1, 1, 0);
    chk("n1.count_c", int'(count), 1);
    window_len = 5;                  // takes effect at this boundary
    tick(1, 1, 0);
    chk("n1.cv_d", int'(count_valid), 1);
    tick(1, 1, 0); tick(1, 1, 0);
    chk("len5.rc2", int'(running_count), 2);
    chk("len5.no_cv", int'(count_valid), 0);

    // Asynchronous reset mid-window: outputs drop with no clock edge.
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk); #2;
    reset = 1'b0;
    tick(0, 0, 0);
    chk("post_reset.cv", int'(count_valid), 0);
    chk("post_reset.rc", int'(running_count), 0);

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_match_window_counter.md
# pattern_match_window_counter

Downstream consumer of the serial pattern detector's match pulse `z`. Counts asserted-`z` cycles inside consecutive programmable windows of N clock cycles. Reports each window's total with a one-cycle valid strobe, and raises sticky alarm and overflow flags for the control logic.

## Interface
- `CNT_W`, default 8: width of the match accumulator and of reported counts.
- `WIN_W`, default 16: width of the window length.

- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `z`, in, 1: match pulse from the pattern detector. Sampled only in state RUN.
- `enable`, in, 1: level. Starts windowing and keeps it running.
- `clear`, in, 1: synchronous clear of all counters, flags and the FSM.
- `window_len`, in, `WIN_W`: window length in cycles. Sampled in LOAD and at each window boundary. 0 is treated as 1.
- `threshold`, in, `CNT_W`: alarm threshold. 0 disables the alarm.
- `count`, out, `CNT_W`: total of the last completed window. Holds until the next report.
- `count_valid`, out, 1: one-cycle strobe marking a new `count`.
- `running_count`, out, `CNT_W`: live accumulator value.
- `alarm`, out, 1: sticky. Set when a completed window has `count >= threshold` and `threshold != 0`.
- `overflow`, out, 1: sticky. Set when `z=1` arrives while the accumulator is at its maximum.

## Operation
- **Reset values.** All outputs 0, state IDLE, accumulator 0, timer 0, latched length 0.
- **FSM states.** IDLE, LOAD, RUN.
- **IDLE.** Accumulator held at 0. If `enable=1`, go to LOAD.
- **LOAD.** Latch `max(window_len, 1)` into the timer. Accumulator 0. `z` is ignored. Go to RUN.
- **RUN, each cycle:**
  - If `z=1`, accumulator increments, saturating at `2^CNT_W-1`.
  - If `z=1` while the accumulator is already saturated, set `overflow`.
  - Timer decrements.
- **Window boundary (last RUN cycle, timer == 1):**
  - Final value is `acc + z`, saturated.
  - On the closing edge, `count` takes the final value and `count_valid` goes to 1 for exactly one cycle.
  - `alarm` is set if the final value is `>= threshold` and `threshold != 0`.
  - If `enable=1`, the timer reloads from `max(window_len, 1)`, the accumulator restarts at 0 and the FSM stays in RUN. Windows are back-to-back with no gap cycle.
  - If `enable=0`, go to IDLE.
- **`enable` low in a non-final RUN cycle.** The window is aborted. Go to IDLE with accumulator 0. No `count_valid`. `count` and the flags are unchanged.
- **`clear=1`.**
  - Next edge: state IDLE; `count`, `running_count`, `alarm`, `overflow` and timer all 0; `count_valid` 0.
  - `clear` overrides a simultaneous window boundary and a simultaneous `z`.
  - Priority order: `reset` > `clear` > boundary/abort > increment.
- **Width rules.**
  - Timer is `WIN_W` bits. The accumulator never wraps.
  - Comparison is unsigned.
  - `running_count` equals the accumulator register (pre-add value for the current cycle).

## Timing
- `enable` sampled high in IDLE at cycle k:
  - LOAD at k+1.
  - RUN for cycles k+2 … k+1+N.
  - `count_valid` high at cycle k+2+N.
- While `enable` stays high, subsequent reports come every N cycles. `count_valid` coincides with the first RUN cycle of the next window.
- `z` pulses in IDLE or LOAD are never counted.
- `count_valid` is never high for two consecutive cycles unless N=1. With N=1, it is high every cycle while enabled.
- `alarm` and `overflow` update on the same edge that raises `count_valid`. `overflow` may also update on any RUN edge.
- `reset` asserted mid-window: everything returns to reset values immediately. No report is produced. Operation resumes from IDLE after deassertion.
- A change to `window_len` during RUN takes effect only at the next boundary.

## Test plan
- **Basic window count.** `window_len=4`, `enable` held, `z` = 1,0,1,1 in the four RUN cycles -> `count=3` with a one-cycle `count_valid` at k+6. `running_count` reads 0,1,1,2 during the window.
- **Back-to-back windows.** `window_len=3`, `z` = 1,1,1 then 0,1,0 -> reports 3, then 1, with `count_valid` exactly 3 cycles apart. No gap cycle.
- **Saturation.** `CNT_W=8`, `window_len=300`, `z=1` in every cycle -> `count=255`, `overflow=1` (sticky after the window). `alarm=1` when `threshold=200`.
- **Mid-window abort.** `window_len=10`, drop `enable` after 5 RUN cycles with `z=1` -> no `count_valid`, `count` keeps its previous value, FSM returns to IDLE.
- **Clear at boundary.** `clear` and window boundary in the same cycle (with `alarm` already set) -> no `count_valid`, all outputs 0, state IDLE.
- **Edge lengths and reset.** `window_len=0` -> behaves as N=1, with `count_valid` every cycle and `count` equal to the prior-cycle `z`. Assert `reset` mid-window -> outputs 0 immediately, without waiting for a clock edge.
